// File: rtl/seq_detect_pkg.sv
// Shared encodings and default sizes for the serial pattern-recognition controller.
package seq_detect_pkg;

  localparam int W_DEF       = 8;
  localparam int PAT_MAX_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_SHIFT = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/seq_window_match.sv
// Recognition window: shift register, saturating bits-seen counter and masked compare.
// hit is evaluated on the post-shift window so the caller can register it on the shifting edge.
module seq_window_match
  import seq_detect_pkg::*;
#(
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_en,
  input  logic               bit_in,
  input  logic               clear,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_MAX);

  logic [PAT_MAX-1:0] r_window;
  logic [LEN_W-1:0]   r_bits_seen;

  logic [PAT_MAX-1:0] w_win_next;
  logic [LEN_W-1:0]   w_bits_next;
  logic [LEN_W-1:0]   w_len_eff;
  logic [PAT_MAX-1:0] w_mask;

  assign w_win_next  = {r_window[PAT_MAX-2:0], bit_in};
  assign w_bits_next = (r_bits_seen == LEN_MAX) ? r_bits_seen : r_bits_seen + 1'b1;
  assign w_len_eff   = (len > LEN_MAX) ? LEN_MAX : len;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      if (i < int'(w_len_eff)) w_mask[i] = 1'b1;
    end
  end

  assign hit = shift_en && (w_len_eff != '0) && (w_bits_next >= w_len_eff) &&
               (((w_win_next ^ pattern) & w_mask) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_window    <= '0;
      r_bits_seen <= '0;
    end else if (clear) begin
      r_window    <= '0;
      r_bits_seen <= '0;
    end else if (shift_en) begin
      r_window    <= w_win_next;
      r_bits_seen <= w_bits_next;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Frame controller: accepts words, serializes them MSB-first into the matcher, counts matches.
// Optional early termination via the abort input when SEQ_DETECT_ABORT_EN is defined.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  localparam int LEN_W  = $clog2(PAT_MAX + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               in_valid,
  input  logic [W-1:0]       in_data,
  input  logic               in_last,
`ifdef SEQ_DETECT_ABORT_EN
  input  logic               abort,
`endif
  output logic               in_ready,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done
);

  localparam int BIT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             r_state;
  logic [PAT_MAX-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic [W-1:0]       r_word;
  logic               r_last;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic               r_in_ready;
  logic               r_match_pulse;
  logic [CNT_W-1:0]   r_match_count;
  logic               r_done;

  logic w_abort;
  logic w_shift_en;
  logic w_clear;
  logic w_hit;

`ifdef SEQ_DETECT_ABORT_EN
  assign w_abort = abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // An aborting cycle must not shift, so no match can land on the abort edge.
  assign w_shift_en = (r_state == S_SHIFT) && !w_abort;
  assign w_clear    = (r_state == S_IDLE) && start;

  seq_window_match #(
    .PAT_MAX (PAT_MAX),
    .LEN_W   (LEN_W)
  ) u_match (
    .clk      (clk),
    .reset    (reset),
    .shift_en (w_shift_en),
    .bit_in   (r_word[r_bit_cnt]),
    .clear    (w_clear),
    .pattern  (r_pattern),
    .len      (r_len),
    .hit      (w_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pattern     <= '0;
      r_len         <= '0;
      r_word        <= '0;
      r_last        <= 1'b0;
      r_bit_cnt     <= '0;
      r_in_ready    <= 1'b0;
      r_match_pulse <= 1'b0;
      r_match_count <= '0;
      r_done        <= 1'b0;
    end else begin
      r_match_pulse <= w_hit;
      r_done        <= 1'b0;
      if (w_hit && (r_match_count != CNT_MAX)) r_match_count <= r_match_count + 1'b1;

      if (w_abort) begin
        r_state    <= S_IDLE;
        r_in_ready <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_pattern     <= cfg_pattern;
              r_len         <= cfg_len;
              r_match_count <= '0;
              r_in_ready    <= 1'b1;
              r_state       <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (in_valid && r_in_ready) begin
              r_word     <= in_data;
              r_last     <= in_last;
              r_bit_cnt  <= BIT_W'(W - 1);
              r_in_ready <= 1'b0;
              r_state    <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            // Bit index counts down so the MSB goes first and zero is the terminal count.
            if (r_bit_cnt == '0) begin
              if (r_last) begin
                r_state <= S_FLUSH;
              end else begin
                r_in_ready <= 1'b1;
                r_state    <= S_WAIT;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt - 1'b1;
            end
          end
          S_FLUSH: begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_in_ready <= 1'b0;
            r_state    <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign match_pulse = r_match_pulse;
  assign match_count = r_match_count;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: table of single frames plus multi-cycle corner sequences.
module tb_seq_detect_ctrl;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
`ifdef SEQ_DETECT_ABORT_EN
  logic       abort;
`endif

  logic       in_ready, match_pulse, busy, done;
  logic [7:0] match_count;
  logic       s_in_ready, s_match_pulse, s_busy, s_done;
  logic [1:0] s_match_count;

  seq_detect_ctrl u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
`ifdef SEQ_DETECT_ABORT_EN
    .abort       (abort),
`endif
    .in_ready    (in_ready),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .busy        (busy),
    .done        (done)
  );

  seq_detect_ctrl #(.CNT_W(2)) u_dut_sat (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
`ifdef SEQ_DETECT_ABORT_EN
    .abort       (abort),
`endif
    .in_ready    (s_in_ready),
    .match_pulse (s_match_pulse),
    .match_count (s_match_count),
    .busy        (s_busy),
    .done        (s_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0, sat_pulses = 0, dones = 0, accepts = 0;

  always @(negedge clk) begin
    if (match_pulse)   pulses++;
    if (s_match_pulse) sat_pulses++;
    if (done)          dones++;
  end

  always @(posedge clk) begin
    if (in_valid && in_ready) accepts++;
  end

  typedef struct {
    logic [7:0] pat;
    logic [3:0] len;
    int         nw;
    logic [7:0] w0;
    logic [7:0] w1;
    int         exp_n;
  } vec_t;

  vec_t vecs[8];

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] pat, input logic [3:0] len);
    start       = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    @(posedge clk);
    @(negedge clk);
    start       = 1'b0;
    cfg_pattern = ~pat;
    cfg_len     = 4'd1;
    check("start_clr", match_count, 0);
    check("start_ready", in_ready, 1);
  endtask

  task automatic send_word(input logic [7:0] data, input logic last);
    int k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("ready_drop", in_ready, 0);
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic run_vector(input int idx, input vec_t v);
    int p0, s0, d0, k;
    p0 = pulses; s0 = sat_pulses; d0 = dones;
    start_frame(v.pat, v.len);
    send_word(v.w0, v.nw == 1);
    if (v.nw == 2) send_word(v.w1, 1'b1);
    wait_done(k);
    check($sformatf("v%0d_done_lat", idx), k, W + 1);
    @(negedge clk);
    check($sformatf("v%0d_done_width", idx), done, 0);
    check($sformatf("v%0d_busy_end", idx), busy, 0);
    check($sformatf("v%0d_pulses", idx), pulses - p0, v.exp_n);
    check($sformatf("v%0d_count", idx), match_count, imin(v.exp_n, 255));
    check($sformatf("v%0d_sat_pulses", idx), sat_pulses - s0, v.exp_n);
    check($sformatf("v%0d_sat_count", idx), s_match_count, imin(v.exp_n, 3));
    check($sformatf("v%0d_dones", idx), dones - d0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0, a0, d0, k, zeros;

    vecs[0] = '{8'h05, 4'd3, 1, 8'hAA, 8'h00, 3};
    vecs[1] = '{8'h05, 4'd3, 2, 8'h02, 8'h80, 1};
    vecs[2] = '{8'h01, 4'd1, 1, 8'hFF, 8'h00, 8};
    vecs[3] = '{8'h01, 4'd0, 1, 8'hFF, 8'h00, 0};
    vecs[4] = '{8'hA5, 4'd8, 1, 8'hA5, 8'h00, 1};
    vecs[5] = '{8'hFF, 4'd9, 2, 8'hFF, 8'hFF, 9};
    vecs[6] = '{8'h03, 4'd2, 1, 8'h0F, 8'h00, 3};
    vecs[7] = '{8'hF8, 4'd3, 2, 8'h00, 8'h00, 14};

    reset = 1'b1; start = 1'b0; cfg_pattern = '0; cfg_len = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
`ifdef SEQ_DETECT_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_count", match_count, 0);
    check("rst_pulse", match_pulse, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vector(i, vecs[i]);

    // Cross-word match: pulse one cycle after word 2 accept
    start_frame(8'h05, 4'd3);
    send_word(8'h02, 1'b0);
    send_word(8'h80, 1'b1);
    k = 0;
    while (!match_pulse && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("xw_pulse_lat", k, 1);
    wait_done(k);
    @(negedge clk);
    check("xw_count", match_count, 1);

    // Held in_valid during SHIFT and a mid-frame start
    p0 = pulses; a0 = accepts;
    start_frame(8'h01, 4'd1);
    in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    zeros = 0;
    for (int i = 0; i < 8; i++) begin
      if (!in_ready) zeros++;
      start = (i == 3);
      @(negedge clk);
    end
    start = 1'b0;
    check("bp_ready_low", zeros, 8);
    check("bp_ready_back", in_ready, 1);
    check("bp_busy", busy, 1);
    check("bp_mid_count", match_count, 8);
    in_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    wait_done(k);
    @(negedge clk);
    check("bp_accepts", accepts - a0, 2);
    check("bp_pulses", pulses - p0, 16);
    check("bp_count", match_count, 16);
    check("bp_sat_count", s_match_count, 3);

    // Asynchronous reset between edges during SHIFT
    start_frame(8'h01, 4'd1);
    send_word(8'hFF, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_count", match_count, 0);
    check("arst_pulse", match_pulse, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", in_ready, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_vector(10, vecs[0]);

`ifdef SEQ_DETECT_ABORT_EN
    d0 = dones;
    start_frame(8'h01, 4'd1);
    send_word(8'h80, 1'b1);
    @(negedge clk);
    check("ab_pre_count", match_count, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_count", match_count, 1);
    check("ab_ready", in_ready, 0);
    repeat (12) @(negedge clk);
    check("ab_no_done", dones - d0, 0);
    check("ab_count_hold", match_count, 1);
`else
    d0 = dones;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Controller that sequences a bit-serial pattern recognizer over a frame of parallel words. It accepts a runtime-configured pattern (up to PAT_MAX bits, overlapping matches allowed) and takes words on a valid/ready port. It serializes each word MSB-first into an internal recognition window, then counts matches and reports completion at end of frame. It sits between a word-producing source and the status/interrupt logic that consumes the match count.

Parameters:
W, 8, input word width (bits serialized per word)
PAT_MAX, 8, maximum pattern length in bits
CNT_W, 8, match counter width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin a frame; sampled only in IDLE
cfg_pattern  input  PAT_MAX  pattern; LSB = most recent bit; latched on accepted start
cfg_len  input  $clog2(PAT_MAX+1)  pattern length; latched on accepted start
in_valid  input  1  word valid
in_data  input  W  word, serialized MSB first
in_last  input  1  word is last of frame; qualified by in_valid
in_ready  output  1  controller can accept a word
match_pulse  output  1  one-cycle pulse per match
match_count  output  CNT_W  matches in current/last frame, saturating
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset, asynchronous: state=IDLE; window, bits_seen, match_count, match_pulse, done, in_ready=0; latched cfg cleared.
- States: IDLE, WAIT, SHIFT, FLUSH, DONE.
- IDLE: start=1 -> latch cfg_pattern/cfg_len; clear window, bits_seen, match_count -> WAIT. match_count holds the last frame's value until the next start.
- WAIT: in_ready=1 (registered, asserted on entry). On in_valid&&in_ready: latch word and in_last -> SHIFT; in_ready drops next cycle.
- SHIFT: one bit per cycle, MSB first, shifted into window LSB. bits_seen increments, saturating at PAT_MAX. After W bits: last word -> FLUSH, else -> WAIT.
- FLUSH: one cycle so the final bit's match_pulse and count update land before done -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- Match condition, evaluated after each shift: L>=1, bits_seen>=L, and window[L-1:0]==pattern[L-1:0]. Here L = min(cfg_len, PAT_MAX). L=0 never matches.
- Match output: registered. match_pulse is high the cycle after the edge that shifted in the completing bit. match_count increments on that same edge and saturates at 2^CNT_W-1.
- Window is not cleared on a match (overlapping matches allowed). The window persists across words within a frame, so matches may span word boundaries.
- start outside IDLE is ignored; cfg changes outside IDLE have no effect.
- in_valid with in_ready=0: the word is not consumed; the source must hold it.
- Throughput: one word per W+1 cycles (W shifts plus one accept cycle).

Optional Feature:
- Macro: SEQ_DETECT_ABORT_EN.
- Defined: adds input abort (1 bit). abort=1 in any state other than IDLE -> IDLE on the next edge. done is not pulsed; match_count holds; in_ready deasserts. abort has priority over all other transitions, including a same-cycle word accept.
- Undefined: no abort port; a frame runs until in_last, and only reset terminates it early.

Decomposition:
- Shared package seq_detect_pkg: state enum encodings (IDLE..DONE) and defaults for W, PAT_MAX, CNT_W.
- One sub-module, seq_window_match: window shift register, bits_seen saturating counter and the masked compare. Interface: shift_en, bit_in, clear, pattern, len -> hit.
- The controller FSM, handshake, bit index counter and match counter live in seq_detect_ctrl.

Test Plan:
- pattern=3'b101, len=3, one word 8'b10101010 with last -> 3 match_pulses; match_count=3; done 1 cycle after FLUSH.
- Cross-word: words 8'b00000010, then 8'b10000000 with last, pattern 101 -> exactly 1 match, its pulse during the first SHIFT cycle of word 2 + 1; count=1.
- Saturation: CNT_W=2, pattern=1'b1, len=1, word 8'hFF with last -> 8 pulses; match_count=3.
- Backpressure/start: in_valid held during SHIFT -> no extra word consumed. start pulsed while busy -> ignored; count not cleared.
- Reset asserted mid-SHIFT, asynchronously between edges -> outputs zero immediately; IDLE. A new frame then counts from 0.
- With SEQ_DETECT_ABORT_EN: abort in SHIFT with count=1 -> IDLE next edge, no done, count stays 1.
